// File: rtl/dcache_bus_pkg.sv
// dcache_bus_pkg
//   Shared definitions for the dcache line refill/writeback bus and its
//   SRAM bridge: bridge FSM states, line geometry and the line-address
//   field helper.
package dcache_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } bus_state_t;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned WORD_BITS  = 32;
    localparam int unsigned LINE_BITS  = LINE_WORDS * WORD_BITS;

    // Line address field of a byte address (bits [31:4]); callers narrow
    // the result to the SRAM line-address width.
    function automatic logic [27:0] line_field(input logic [31:4] byte_addr_hi);
        return byte_addr_hi;
    endfunction

endpackage

// File: rtl/dcache_line_mem_bridge_timer.sv
// sram_word_timer
//   Cycle counter for one SRAM word access of ACCESS_CYCLES clocks.
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     run        count while a word access is in progress; held at 0 otherwise
//     word_last  current cycle is the last cycle of the word
//     hold_nxt   the next cycle will be the last of its word (write hold
//                cycle); used to register sram_we_n one cycle ahead
module sram_word_timer #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic word_last,
    output logic hold_nxt
);

    localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    logic [CW-1:0] cyc;
    logic [CW-1:0] cyc_nxt;

    assign word_last = (cyc == LAST);

    always_comb begin
        cyc_nxt = '0;
        if (run && !word_last) begin
            cyc_nxt = cyc + 1'b1;
        end
    end

    assign hold_nxt = (cyc_nxt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc <= '0;
        end else begin
            cyc <= cyc_nxt;
        end
    end

endmodule

// File: rtl/dcache_line_mem_bridge.sv
// dcache_line_mem_bridge
//   Memory-side responder for the dcache line bus. Each 128-bit line read or
//   write is served as four ascending 32-bit accesses to an asynchronous
//   word SRAM. All SRAM pins are registered; the tri-state buffer for the
//   data bus lives above this block (sram_doe enables it).
//   Ports:
//     clk, rst                       clock, asynchronous active-low reset
//     cpu_ren/cpu_raddr              line read request (any nonzero ren)
//     dev_rrdy, dev_rvalid, dev_rdata read ready, completion pulse, line data
//     cpu_wen/cpu_waddr/cpu_wdata    line write request (any nonzero wen)
//     dev_wrdy                       write ready
//     sram_*                         word SRAM address/data/control pins
module dcache_line_mem_bridge
    import dcache_bus_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned SRAM_AW       = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           cpu_ren,
    input  logic [31:0]          cpu_raddr,
    output logic                 dev_rrdy,
    output logic                 dev_rvalid,
    output logic [LINE_BITS-1:0] dev_rdata,
    input  logic [3:0]           cpu_wen,
    input  logic [31:0]          cpu_waddr,
    input  logic [LINE_BITS-1:0] cpu_wdata,
    output logic                 dev_wrdy,
    output logic [SRAM_AW-1:0]   sram_addr,
    input  logic [31:0]          sram_din,
    output logic [31:0]          sram_dout,
    output logic                 sram_doe,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [3:0]           sram_be_n
);

    localparam int unsigned LAW = SRAM_AW - 2;

    bus_state_t             state;
    logic                   pend_rd;
    logic [LAW-1:0]         pend_addr;
    logic [LAW-1:0]         line_addr;
    logic [1:0]             word_cnt;
    logic [1:0]             word_nxt;
    logic [LINE_BITS-1:0]   wdata_q;
    logic                   word_last;
    logic                   hold_nxt;
    logic [LAW-1:0]         rd_line;
    logic [LAW-1:0]         wr_line;
    logic                   unused_addr_lo;

    assign unused_addr_lo = ^{cpu_raddr[3:0], cpu_waddr[3:0]};

    assign rd_line  = LAW'(line_field(cpu_raddr[31:4]));
    assign wr_line  = LAW'(line_field(cpu_waddr[31:4]));
    assign word_nxt = word_cnt + 2'd1;

    assign dev_rrdy = (state == ST_IDLE) && !pend_rd;
    assign dev_wrdy = (state == ST_IDLE);

    sram_word_timer #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run      ((state == ST_RD) || (state == ST_WR)),
        .word_last(word_last),
        .hold_nxt (hold_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pend_rd    <= 1'b0;
            pend_addr  <= '0;
            line_addr  <= '0;
            word_cnt   <= '0;
            wdata_q    <= '0;
            dev_rvalid <= 1'b0;
            dev_rdata  <= '0;
            sram_addr  <= '0;
            sram_dout  <= '0;
            sram_doe   <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= '1;
        end else begin
            dev_rvalid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cpu_wen != '0) begin
                        // Write wins a same-cycle collision; the read is
                        // parked in the pending slot and run afterwards.
                        state     <= ST_WR;
                        line_addr <= wr_line;
                        wdata_q   <= cpu_wdata;
                        word_cnt  <= '0;
                        sram_addr <= {wr_line, 2'b00};
                        sram_dout <= cpu_wdata[31:0];
                        sram_doe  <= 1'b1;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= hold_nxt;
                        sram_be_n <= '0;
                        if (cpu_ren != '0) begin
                            pend_rd   <= 1'b1;
                            pend_addr <= rd_line;
                        end
                    end else if ((cpu_ren != '0) && !pend_rd) begin
                        state     <= ST_RD;
                        line_addr <= rd_line;
                        word_cnt  <= '0;
                        sram_addr <= {rd_line, 2'b00};
                        sram_doe  <= 1'b0;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_we_n <= 1'b1;
                        sram_be_n <= '0;
                    end
                end
                ST_WR: begin
                    if (word_last && (word_cnt == 2'd3)) begin
                        sram_doe  <= 1'b0;
                        sram_we_n <= 1'b1;
                        if (pend_rd) begin
                            state     <= ST_RD;
                            pend_rd   <= 1'b0;
                            line_addr <= pend_addr;
                            word_cnt  <= '0;
                            sram_addr <= {pend_addr, 2'b00};
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                            sram_be_n <= '0;
                        end else begin
                            state     <= ST_IDLE;
                            sram_ce_n <= 1'b1;
                            sram_oe_n <= 1'b1;
                            sram_be_n <= '1;
                        end
                    end else begin
                        if (word_last) begin
                            word_cnt  <= word_nxt;
                            sram_addr <= {line_addr, word_nxt};
                            sram_dout <= wdata_q[{word_nxt, 5'd0} +: 32];
                        end
                        sram_we_n <= hold_nxt;
                    end
                end
                ST_RD: begin
                    if (word_last) begin
                        dev_rdata[{word_cnt, 5'd0} +: 32] <= sram_din;
                        if (word_cnt == 2'd3) begin
                            state      <= ST_DONE;
                            dev_rvalid <= 1'b1;
                            sram_ce_n  <= 1'b1;
                            sram_oe_n  <= 1'b1;
                            sram_be_n  <= '1;
                        end else begin
                            word_cnt  <= word_nxt;
                            sram_addr <= {line_addr, word_nxt};
                        end
                    end
                end
                ST_DONE: begin
                    if (pend_rd) begin
                        state     <= ST_RD;
                        pend_rd   <= 1'b0;
                        line_addr <= pend_addr;
                        word_cnt  <= '0;
                        sram_addr <= {pend_addr, 2'b00};
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_be_n <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_line_mem_bridge.sv
// tb_dcache_line_mem_bridge
//   Self-checking bench: a word-array SRAM model answers the bridge's pins,
//   and a separate line-level reference memory predicts every read.
module tb_dcache_line_mem_bridge;

    localparam int unsigned AC       = 2;
    localparam int unsigned AW       = 20;
    localparam int unsigned LINE_LAT = 4 * AC;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   cpu_ren;
    logic [31:0]  cpu_raddr;
    logic         dev_rrdy;
    logic         dev_rvalid;
    logic [127:0] dev_rdata;
    logic [3:0]   cpu_wen;
    logic [31:0]  cpu_waddr;
    logic [127:0] cpu_wdata;
    logic         dev_wrdy;
    logic [AW-1:0] sram_addr;
    logic [31:0]  sram_din;
    logic [31:0]  sram_dout;
    logic         sram_doe;
    logic         sram_ce_n;
    logic         sram_oe_n;
    logic         sram_we_n;
    logic [3:0]   sram_be_n;

    dcache_line_mem_bridge #(
        .ACCESS_CYCLES(AC),
        .SRAM_AW      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_ren   (cpu_ren),
        .cpu_raddr (cpu_raddr),
        .dev_rrdy  (dev_rrdy),
        .dev_rvalid(dev_rvalid),
        .dev_rdata (dev_rdata),
        .cpu_wen   (cpu_wen),
        .cpu_waddr (cpu_waddr),
        .cpu_wdata (cpu_wdata),
        .dev_wrdy  (dev_wrdy),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .sram_doe  (sram_doe),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_be_n (sram_be_n)
    );

    always #5 clk = ~clk;

    // ---------------- SRAM pin model (device side) ----------------
    logic [31:0]  sram_mem [4096];
    int unsigned  wr_log_addr[$];
    logic [31:0]  wr_log_data[$];
    int unsigned  doe_cycles    = 0;
    int unsigned  we_lo_cycles  = 0;
    int unsigned  rvalid_cycles = 0;

    assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[11:0]] : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            sram_mem[sram_addr[11:0]] = sram_dout;
            if (wr_log_addr.size() == 0 || wr_log_addr[$] != int'(sram_addr)) begin
                wr_log_addr.push_back(int'(sram_addr));
                wr_log_data.push_back(sram_dout);
            end
        end
        if (sram_doe)   doe_cycles++;
        if (!sram_we_n) we_lo_cycles++;
        if (dev_rvalid) rvalid_cycles++;
    end

    // ---------------- line-level reference memory ----------------
    logic [31:0] ref_mem [4096];
    int n_cmp  = 0;
    int n_fail = 0;

    function automatic int unsigned line_base(input logic [31:0] a);
        return int'(a[13:4]) * 4;
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] a);
        int unsigned b;
        b = line_base(a);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [127:0] d);
        int unsigned b;
        b = line_base(a);
        for (int i = 0; i < 4; i++) ref_mem[b+i] = d[32*i +: 32];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        n_cmp++;
        if (!sram_oe_n && (!sram_we_n || sram_doe)) begin
            n_fail++;
            $display("FAIL bus_drive_vs_oe: oe_n=%b we_n=%b doe=%b, required we_n=1 doe=0 while oe_n=0",
                     sram_oe_n, sram_we_n, sram_doe);
        end
    endtask

    task automatic wait_idle;
        int unsigned g;
        g = 0;
        while (!(dev_wrdy && dev_rrdy) && g < 200) begin tick(); g++; end
        n_cmp++;
        if (!(dev_wrdy && dev_rrdy)) begin
            n_fail++;
            $display("FAIL idle_timeout: rrdy=%b wrdy=%b, required 1/1", dev_rrdy, dev_wrdy);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [127:0] d);
        int unsigned busy;
        wait_idle();
        cpu_wen = 4'hF; cpu_waddr = a; cpu_wdata = d;
        tick();
        cpu_wen = 4'h0;
        ref_write(a, d);
        busy = 0;
        while (!dev_wrdy && busy < 200) begin tick(); busy++; end
        n_cmp++;
        if (busy != LINE_LAT) begin
            n_fail++;
            $display("FAIL write_busy_cycles addr=%h: got %0d, required %0d", a, busy, LINE_LAT);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [127:0] d, output int unsigned lat);
        wait_idle();
        cpu_ren = 4'hF; cpu_raddr = a;
        tick();
        cpu_ren = 4'h0;
        lat = 0;
        while (!dev_rvalid && lat < 200) begin tick(); lat++; end
        d = dev_rdata;
        tick();
        n_cmp++;
        if (dev_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rvalid_pulse_width addr=%h: rvalid=%b one cycle after pulse, required 0", a, dev_rvalid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b0; cpu_ren = '0; cpu_wen = '0; cpu_raddr = '0; cpu_waddr = '0; cpu_wdata = '0;
        #23;
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_doe} !== 8'b1111_1110) begin
            n_fail++;
            $display("FAIL reset_sram_ctl: ce/oe/we/be/doe=%b, required 11111110",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_doe});
        end
        n_cmp++;
        if (sram_addr !== '0 || sram_dout !== '0) begin
            n_fail++;
            $display("FAIL reset_sram_bus: addr=%h dout=%h, required 0/0", sram_addr, sram_dout);
        end
        n_cmp++;
        if (dev_rvalid !== 1'b0 || dev_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rd_out: rvalid=%b rdata=%h, required 0/0", dev_rvalid, dev_rdata);
        end
        n_cmp++;
        if (dev_rrdy !== 1'b1 || dev_wrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: rrdy=%b wrdy=%b, required 1/1", dev_rrdy, dev_wrdy);
        end
    endtask

    task automatic test_single_write;
        int unsigned  log0, doe0, we0, rv0;
        logic [127:0] d;
        d = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
        wait_idle();
        log0 = wr_log_addr.size(); doe0 = doe_cycles; we0 = we_lo_cycles; rv0 = rvalid_cycles;
        do_write(32'h0000_0040, d);
        tick();
        n_cmp++;
        if (wr_log_addr.size() - log0 != 4) begin
            n_fail++;
            $display("FAIL write_word_count: got %0d words, required 4", wr_log_addr.size() - log0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (wr_log_addr[log0+i] != 32'h10 + i || wr_log_data[log0+i] !== d[32*i +: 32]) begin
                    n_fail++;
                    $display("FAIL write_word%0d: addr=%h data=%h, required addr=%h data=%h", i,
                             wr_log_addr[log0+i], wr_log_data[log0+i], 32'h10 + i, d[32*i +: 32]);
                end
            end
        end
        n_cmp++;
        if (doe_cycles - doe0 != LINE_LAT || we_lo_cycles - we0 != 4 * (AC - 1)) begin
            n_fail++;
            $display("FAIL write_strobes: doe cycles=%0d we_n low=%0d, required %0d/%0d",
                     doe_cycles - doe0, we_lo_cycles - we0, LINE_LAT, 4 * (AC - 1));
        end
        n_cmp++;
        if (rvalid_cycles != rv0) begin
            n_fail++;
            $display("FAIL write_no_rvalid: rvalid cycles=%0d, required 0", rvalid_cycles - rv0);
        end
    endtask

    task automatic test_single_read;
        logic [127:0] d;
        int unsigned  lat, rv0;
        do_write(32'h0000_1230, 128'h44444444_33333333_22222222_11111111);
        rv0 = rvalid_cycles;
        do_read(32'h0000_1230, d, lat);
        tick();
        n_cmp++;
        if (lat != LINE_LAT) begin
            n_fail++;
            $display("FAIL read_latency: got %0d, required %0d", lat, LINE_LAT);
        end
        n_cmp++;
        if (d !== 128'h44444444_33333333_22222222_11111111) begin
            n_fail++;
            $display("FAIL read_data: got %h, required %h", d, 128'h44444444_33333333_22222222_11111111);
        end
        n_cmp++;
        if (rvalid_cycles - rv0 != 1) begin
            n_fail++;
            $display("FAIL read_rvalid_count: got %0d, required 1", rvalid_cycles - rv0);
        end
    endtask

    task automatic test_simultaneous;
        logic [127:0] wd, rd, d2;
        int unsigned  lat, rdy_hi, l2;
        do_write(32'h0000_0080, {$urandom, $urandom, $urandom, $urandom});
        wd = {$urandom, $urandom, $urandom, $urandom};
        wait_idle();
        cpu_wen = 4'hF; cpu_waddr = 32'h40; cpu_wdata = wd;
        cpu_ren = 4'hF; cpu_raddr = 32'h80;
        tick();
        cpu_wen = '0; cpu_ren = '0;
        ref_write(32'h40, wd);
        lat = 0; rdy_hi = 0;
        while (!dev_rvalid && lat < 200) begin
            if (dev_rrdy) rdy_hi++;
            tick(); lat++;
        end
        rd = dev_rdata;
        n_cmp++;
        if (lat != 2 * LINE_LAT) begin
            n_fail++;
            $display("FAIL simul_latency: got %0d, required %0d", lat, 2 * LINE_LAT);
        end
        n_cmp++;
        if (rdy_hi != 0 || dev_rrdy !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_rrdy: rrdy high %0d cycles, required 0", rdy_hi);
        end
        n_cmp++;
        if (rd !== ref_line(32'h80)) begin
            n_fail++;
            $display("FAIL simul_read_data: got %h, required %h", rd, ref_line(32'h80));
        end
        do_read(32'h40, d2, l2);
        n_cmp++;
        if (d2 !== wd || l2 != LINE_LAT) begin
            n_fail++;
            $display("FAIL simul_write_data: got %h lat %0d, required %h lat %0d", d2, l2, wd, LINE_LAT);
        end
    endtask

    task automatic test_read_while_busy;
        logic [127:0] wd;
        int unsigned  k, lat;
        logic         rb;
        wd = {$urandom, $urandom, $urandom, $urandom};
        wait_idle();
        cpu_wen = 4'hF; cpu_waddr = 32'h100; cpu_wdata = wd;
        tick();
        cpu_wen = '0;
        ref_write(32'h100, wd);
        cpu_ren = 4'hF; cpu_raddr = 32'h80;
        k = 0; rb = 1'b0;
        while (!rb && k < 200) begin
            rb = dev_rrdy;
            tick(); k++;
        end
        cpu_ren = '0;
        n_cmp++;
        if (k != LINE_LAT + 1) begin
            n_fail++;
            $display("FAIL busy_read_accept_edge: accepted at edge %0d, required %0d", k, LINE_LAT + 1);
        end
        lat = 0;
        while (!dev_rvalid && lat < 200) begin tick(); lat++; end
        n_cmp++;
        if (lat != LINE_LAT || dev_rdata !== ref_line(32'h80)) begin
            n_fail++;
            $display("FAIL busy_read_result: lat %0d data %h, required lat %0d data %h",
                     lat, dev_rdata, LINE_LAT, ref_line(32'h80));
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] da, db;
        int unsigned  lat, k, m;
        logic         rb;
        wait_idle();
        cpu_ren = 4'hF; cpu_raddr = 32'h80;
        tick();
        cpu_ren = '0;
        lat = 0;
        while (!dev_rvalid && lat < 200) begin tick(); lat++; end
        da = dev_rdata;
        db = ref_line(32'h40);
        n_cmp++;
        if (da !== ref_line(32'h80) || lat != LINE_LAT) begin
            n_fail++;
            $display("FAIL b2b_first: data %h lat %0d, required %h lat %0d", da, lat, ref_line(32'h80), LINE_LAT);
        end
        cpu_ren = 4'hF; cpu_raddr = 32'h40;
        k = 0; rb = 1'b0;
        while (!rb && k < 200) begin
            rb = dev_rrdy;
            tick(); k++;
        end
        cpu_ren = '0;
        m = 0;
        while (m < 200) begin
            tick(); m++;
            if (m < AC) begin
                n_cmp++;
                if (dev_rdata !== da) begin
                    n_fail++;
                    $display("FAIL b2b_hold m=%0d: rdata %h, required %h", m, dev_rdata, da);
                end
            end else if (m == AC) begin
                n_cmp++;
                if (dev_rdata !== {da[127:32], db[31:0]}) begin
                    n_fail++;
                    $display("FAIL b2b_word0_capture: rdata %h, required %h", dev_rdata, {da[127:32], db[31:0]});
                end
            end
            if (dev_rvalid) break;
        end
        n_cmp++;
        if (k + m != LINE_LAT + 2 || dev_rdata !== db) begin
            n_fail++;
            $display("FAIL b2b_second: gap %0d data %h, required gap %0d data %h", k + m, dev_rdata, LINE_LAT + 2, db);
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] d;
        int unsigned  lat, rv;
        wait_idle();
        cpu_ren = 4'hF; cpu_raddr = 32'h40;
        tick();
        cpu_ren = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_doe} !== 8'b1111_1110 || dev_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ctl: ce/oe/we/be/doe=%b rvalid=%b, required 11111110 rvalid=0",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_doe}, dev_rvalid);
        end
        #2;
        rst = 1'b1;
        rv = 0;
        for (int i = 0; i < 3 * LINE_LAT; i++) begin
            tick();
            if (dev_rvalid) rv++;
        end
        n_cmp++;
        if (rv != 0 || dev_rrdy !== 1'b1 || dev_wrdy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_after: rvalid cycles %0d rrdy=%b wrdy=%b, required 0/1/1", rv, dev_rrdy, dev_wrdy);
        end
        do_read(32'h40, d, lat);
        n_cmp++;
        if (d !== ref_line(32'h40) || lat != LINE_LAT) begin
            n_fail++;
            $display("FAIL midreset_reread: data %h lat %0d, required %h lat %0d", d, lat, ref_line(32'h40), LINE_LAT);
        end
    endtask

    task automatic test_random;
        logic [31:0]  a;
        logic [127:0] d;
        int unsigned  lat;
        for (int l = 0; l < 16; l++) begin
            do_write(32'h400 + 32'(l) * 16, {$urandom, $urandom, $urandom, $urandom});
        end
        for (int n = 0; n < 40; n++) begin
            a = 32'h400 + 32'($urandom_range(0, 15)) * 16 + 32'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, {$urandom, $urandom, $urandom, $urandom});
            end else begin
                do_read(a, d, lat);
                n_cmp++;
                if (d !== ref_line(a) || lat != LINE_LAT) begin
                    n_fail++;
                    $display("FAIL random_read addr=%h: data %h lat %0d, required %h lat %0d",
                             a, d, lat, ref_line(a), LINE_LAT);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_simultaneous();
        test_read_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
